// File: rtl/vector_load_unit.sv
// Vector load unit: gathers LANES strided scalar reads from data memory into one
// packed vector, then hands it to the vector register with a one-cycle write strobe.
module vector_load_unit #(
  parameter int WIDTH  = 4,
  parameter int LANES  = 2,
  parameter int ADDR_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W-1:0]           stride,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [WIDTH-1:0]            mem_data,
  input  logic                        mem_valid,
  output logic [LANES-1:0][WIDTH-1:0] vec_data,
  output logic                        vec_we,
  output logic                        busy,
  output logic                        done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  state_t            state;
  state_t            next_state;
  logic [LANE_W-1:0] lane_cnt;
  logic [ADDR_W-1:0] stride_q;
  logic              last_lane;
  logic              capture;
  logic              mem_rd_d;
  logic              vec_we_d;
  logic              busy_d;

  assign last_lane = (lane_cnt == LAST_LANE);
  assign capture   = (state == WAIT) && mem_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     next_state = WAIT;
      WAIT:    if (mem_valid) next_state = last_lane ? WRITE : REQ;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    mem_rd_d = (next_state == REQ);
    vec_we_d = (next_state == WRITE);
    busy_d   = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd <= 1'b0;
      vec_we <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      mem_rd <= mem_rd_d;
      vec_we <= vec_we_d;
      done   <= vec_we_d;
      busy   <= busy_d;
    end
  end

  // The address register accumulates the stride per lane, so base + lane*stride
  // wraps naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      stride_q <= '0;
      mem_addr <= '0;
      vec_data <= '0;
    end else if (state == IDLE && start) begin
      lane_cnt <= '0;
      stride_q <= stride;
      mem_addr <= base_addr;
    end else if (capture) begin
      vec_data[lane_cnt] <= mem_data;
      if (!last_lane) begin
        lane_cnt <= lane_cnt + LANE_W'(1);
        mem_addr <= mem_addr + stride_q;
      end
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed bench for vector_load_unit: a small behavioural memory answers each
// read with a chosen latency; every scenario task checks its own results.
module tb_vector_load_unit;

  localparam int WIDTH  = 4;
  localparam int LANES  = 2;
  localparam int ADDR_W = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic [ADDR_W-1:0]           base_addr;
  logic [ADDR_W-1:0]           stride;
  logic                        mem_rd;
  logic [ADDR_W-1:0]           mem_addr;
  logic [WIDTH-1:0]            mem_data;
  logic                        mem_valid;
  logic [LANES-1:0][WIDTH-1:0] vec_data;
  logic                        vec_we;
  logic                        busy;
  logic                        done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [WIDTH-1:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vector_load_unit #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .vec_data  (vec_data),
    .vec_we    (vec_we),
    .busy      (busy),
    .done      (done)
  );

  // Sample point is 1 time unit after each rising edge; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a read strobe, then returns data after lat cycles.
  task automatic serve_lane(input int lat, output logic [ADDR_W-1:0] addr,
                            output logic ok, output int rd_cycles);
    int n;
    n = 0;
    ok = 1'b0;
    addr = '0;
    rd_cycles = 0;
    while (mem_rd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (mem_rd === 1'b1) begin
      ok = 1'b1;
      addr = mem_addr;
      rd_cycles = 1;
      for (int i = 0; i < lat; i++) begin
        tick();
        if (mem_rd === 1'b1) rd_cycles++;
      end
      mem_data  = mem[addr];
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
      mem_data  = '0;
    end
  endtask

  task automatic launch(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s, output int t0);
    base_addr = b;
    stride    = s;
    start     = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    mem_valid = 1'b0;
    mem_data = '0;
    base_addr = '0;
    stride = '0;
    tick();
    tick();
    compared++;
    if ({vec_we, done, busy, mem_rd} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {vec_we, done, busy, mem_rd});
    end
    compared++;
    if (vec_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_vec: got %h expected 00", vec_data);
    end
    compared++;
    if (mem_addr !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_addr: got %h expected 00", mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] a0, a1;
    logic ok0, ok1;
    int r0, r1, t0;
    launch(8'h10, 8'h01, t0);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_busy: got %b expected 1", busy);
    end
    serve_lane(1, a0, ok0, r0);
    serve_lane(1, a1, ok1, r1);
    compared++;
    if ({ok0, ok1} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL basic_rd_timeout: got %b expected 11", {ok0, ok1});
    end
    compared++;
    if ({a0, a1} !== 16'h1011) begin
      mismatched++;
      $display("[TB] FAIL basic_addr: got %h expected 1011", {a0, a1});
    end
    compared++;
    if (r0 !== 1 || r1 !== 1) begin
      mismatched++;
      $display("[TB] FAIL basic_rd_width: got %0d/%0d expected 1/1", r0, r1);
    end
    // vec_we in cycle LANES*(1+L)+1 = 5, i.e. four edges after the start edge.
    compared++;
    if ({vec_we, done} !== 2'b11 || (cyc - t0) !== 4) begin
      mismatched++;
      $display("[TB] FAIL basic_we_timing: got we/done=%b delay=%0d expected 11 delay=4",
               {vec_we, done}, cyc - t0);
    end
    compared++;
    if (vec_data !== 8'hCA) begin
      mismatched++;
      $display("[TB] FAIL basic_vec: got %h expected ca", vec_data);
    end
    tick();
    compared++;
    if ({vec_we, done, busy} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL basic_after: got %b expected 000", {vec_we, done, busy});
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] a0, a1;
    logic ok0, ok1;
    int r0, r1, t0;
    launch(8'hFE, 8'h03, t0);
    serve_lane(1, a0, ok0, r0);
    serve_lane(1, a1, ok1, r1);
    compared++;
    if ({ok0, ok1} !== 2'b11 || {a0, a1} !== 16'hFE01) begin
      mismatched++;
      $display("[TB] FAIL wrap_addr: got ok=%b addr=%h expected ok=11 addr=fe01", {ok0, ok1}, {a0, a1});
    end
    compared++;
    if (vec_we !== 1'b1 || vec_data !== 8'hF3) begin
      mismatched++;
      $display("[TB] FAIL wrap_vec: got we=%b vec=%h expected we=1 vec=f3", vec_we, vec_data);
    end
    tick();
    tick();
  endtask

  task automatic test_latency_and_ignored();
    logic [ADDR_W-1:0] a0, a1;
    logic ok0;
    int r0, t0, early_we, extra_we, extra_rd;
    mem_data  = 4'h5;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    mem_data  = '0;
    tick();
    compared++;
    if (vec_data !== 8'hF3 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stray_valid: got vec=%h busy=%b expected vec=f3 busy=0", vec_data, busy);
    end
    launch(8'h30, 8'h02, t0);
    serve_lane(1, a0, ok0, r0);
    a1 = mem_addr;
    base_addr = 8'h50;
    start = 1'b1;
    early_we = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (vec_we === 1'b1) early_we++;
      tick();
    end
    if (vec_we === 1'b1) early_we++;
    mem_data  = mem[a1];
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    compared++;
    if (ok0 !== 1'b1 || {a0, a1} !== 16'h3032 || early_we !== 0) begin
      mismatched++;
      $display("[TB] FAIL latency_early: got ok=%b addr=%h early_we=%0d expected ok=1 addr=3032 early_we=0",
               ok0, {a0, a1}, early_we);
    end
    compared++;
    if (vec_we !== 1'b1 || (cyc - t0) !== 7 || vec_data !== 8'h49) begin
      mismatched++;
      $display("[TB] FAIL latency_we: got we=%b delay=%0d vec=%h expected we=1 delay=7 vec=49",
               vec_we, cyc - t0, vec_data);
    end
    extra_we = 0;
    extra_rd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vec_we === 1'b1) extra_we++;
      if (mem_rd === 1'b1) extra_rd++;
    end
    compared++;
    if (extra_we !== 0 || extra_rd !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL second_start_ignored: got we=%0d rd=%0d busy=%b expected 0 0 0",
               extra_we, extra_rd, busy);
    end
  endtask

  task automatic test_reset_midload();
    logic [ADDR_W-1:0] a0, a1;
    logic ok0, ok1;
    int r0, r1, t0, stray_we;
    launch(8'h40, 8'h01, t0);
    serve_lane(1, a0, ok0, r0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if ({vec_we, done, busy, mem_rd} !== 4'b0000 || vec_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midload_reset: got flags=%b vec=%h expected 0000 vec=00",
               {vec_we, done, busy, mem_rd}, vec_data);
    end
    mem_data  = 4'hE;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    mem_data  = '0;
    stray_we = 0;
    for (int i = 0; i < 5; i++) begin
      if (vec_we === 1'b1 || mem_rd === 1'b1) stray_we++;
      tick();
    end
    compared++;
    if (stray_we !== 0 || vec_data !== 8'h00 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midload_after_valid: got activity=%0d vec=%h busy=%b expected 0 00 0",
               stray_we, vec_data, busy);
    end
    launch(8'h10, 8'h01, t0);
    serve_lane(1, a0, ok0, r0);
    serve_lane(1, a1, ok1, r1);
    compared++;
    if (vec_we !== 1'b1 || vec_data !== 8'hCA || {a0, a1} !== 16'h1011) begin
      mismatched++;
      $display("[TB] FAIL midload_fresh: got we=%b vec=%h addr=%h expected we=1 vec=ca addr=1011",
               vec_we, vec_data, {a0, a1});
    end
    tick();
  endtask

  task automatic test_broadcast_back_to_back();
    logic [ADDR_W-1:0] a0, a1;
    logic ok0, ok1;
    int r0, r1, t0;
    launch(8'h20, 8'h00, t0);
    serve_lane(1, a0, ok0, r0);
    serve_lane(1, a1, ok1, r1);
    compared++;
    if (vec_we !== 1'b1 || vec_data !== 8'h66 || {a0, a1} !== 16'h2020) begin
      mismatched++;
      $display("[TB] FAIL broadcast: got we=%b vec=%h addr=%h expected we=1 vec=66 addr=2020",
               vec_we, vec_data, {a0, a1});
    end
    // start raised during WRITE must only be taken once IDLE is re-entered.
    base_addr = 8'h10;
    stride    = 8'h01;
    start     = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle_gap: got busy=%b rd=%b expected 0 0", busy, mem_rd);
    end
    tick();
    start = 1'b0;
    serve_lane(1, a0, ok0, r0);
    serve_lane(1, a1, ok1, r1);
    compared++;
    if (vec_we !== 1'b1 || vec_data !== 8'hCA || {a0, a1} !== 16'h1011) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got we=%b vec=%h addr=%h expected we=1 vec=ca addr=1011",
               vec_we, vec_data, {a0, a1});
    end
    tick();
  endtask

  task automatic test_no_spurious();
    int activity;
    start = 1'b0;
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vec_we !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0) activity++;
    end
    compared++;
    if (activity !== 0) begin
      mismatched++;
      $display("[TB] FAIL no_spurious: got %0d active cycles expected 0", activity);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'(i * 7 + 3);
    mem[8'h10] = 4'b1010;
    mem[8'h11] = 4'b1100;
    mem[8'hFE] = 4'b0011;
    mem[8'h01] = 4'b1111;
    mem[8'h20] = 4'b0110;
    mem[8'h30] = 4'b1001;
    mem[8'h32] = 4'b0100;
    test_reset();
    test_basic();
    test_wrap();
    test_latency_and_ignored();
    test_reset_midload();
    test_broadcast_back_to_back();
    test_no_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
